cycle_measure_ctrl: RTL and testbench

- CPU-facing controller that drives the 32-bit trigger input of the clock cycle counter and reads back its 32-bit count.
- Software issues START/STOP/LAP commands over a small memory-mapped register port; the block records elapsed-cycle samples in a FIFO for software to pop.
- Sits between the core's peripheral bus and the cycle counter; used to time context-switch and cache-switch sequences.

---
 rtl/cycle_measure_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cycle_measure_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_measure_ctrl.sv
// -----------------------------------------------------------------------------
// cycle_measure_ctrl
//
// Purpose:
//   CPU-facing controller for the free-running clock cycle counter. Software
//   writes START/STOP/LAP/CLEAR commands. The block drives the counter's
//   trigger input and records elapsed-cycle samples (counter_in - base,
//   modulo 2^32) in a small FIFO that software pops through a register.
//
// Register map (byte addresses):
//   0x00 CMD    (W) writedata[2:0]: 1=START 2=STOP 3=LAP 4=CLEAR; reads 0
//   0x04 STATUS (R) [1:0] state, [2] overflow, [3] fifo_full,
//                   [4] fifo_empty, [8+CNT_W-1:8] fifo_count,
//                   [31] max-lap feature present
//   0x08 DATA   (R) FIFO head, popped on read (0 and no pop when empty)
//   0x0C LAST   (R) most recent captured sample
//   0x10 MAX    (R) largest captured sample (0 when the feature is absent)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   write / read   single-cycle register strobes (independent)
//   address        byte address shared by reads and writes
//   writedata      write data
//   readdata       registered read data, held until the next read
//   readdata_valid one-cycle pulse after each read
//   trigger        to counter: 1 = count, 0 = idle, 2 = stopped
//   counter_in     current counter value
//
// Configuration:
//   CYCLE_MEASURE_MAXLAP_EN - when defined, builds the max-sample register
//   at 0x10 and sets STATUS[31].
// -----------------------------------------------------------------------------
module cycle_measure_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic        read,
    input  logic [7:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdata_valid,
    output logic [31:0] trigger,
    input  logic [31:0] counter_in
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);

    localparam logic [7:0] ADDR_CMD    = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_DATA   = 8'h08;
    localparam logic [7:0] ADDR_LAST   = 8'h0C;
`ifdef CYCLE_MEASURE_MAXLAP_EN
    localparam logic [7:0] ADDR_MAX    = 8'h10;
    localparam logic       MAXLAP_FLAG = 1'b1;
`else
    localparam logic       MAXLAP_FLAG = 1'b0;
`endif

    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_LAP   = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;

    localparam logic [31:0] TRIG_IDLE    = 32'd0;
    localparam logic [31:0] TRIG_COUNT   = 32'd1;
    localparam logic [31:0] TRIG_STOPPED = 32'd2;

    // Encoding matches the STATUS[1:0] field so it can be reported directly.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNTING = 2'b01,
        ST_STOPPED  = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [31:0]    trigger_r;
    logic [31:0]    trigger_nxt_s;
    logic [31:0]    base_r;
    logic [31:0]    last_r;
    logic           overflow_r;
    logic [31:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]    readdata_r;
    logic           readdata_valid_r;
`ifdef CYCLE_MEASURE_MAXLAP_EN
    logic [31:0]    max_r;
`endif

    logic           cmd_wr_s;
    logic [2:0]     cmd_code_s;
    logic           do_start_s;
    logic           do_stop_s;
    logic           do_lap_s;
    logic           do_clear_s;
    logic           capture_s;
    logic           fifo_empty_s;
    logic           fifo_full_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;
    logic [31:0]    elapsed_s;
    logic [31:0]    status_s;
    logic [31:0]    rd_mux_s;
    logic           unused_wdata_s;

    // Only the low three bits carry the command code.
    assign unused_wdata_s = ^writedata[31:3];

    assign cmd_wr_s   = write && (address == ADDR_CMD);
    assign cmd_code_s = writedata[2:0];
    assign do_start_s = cmd_wr_s && (cmd_code_s == CMD_START);
    assign do_stop_s  = cmd_wr_s && (cmd_code_s == CMD_STOP);
    assign do_lap_s   = cmd_wr_s && (cmd_code_s == CMD_LAP);
    assign do_clear_s = cmd_wr_s && (cmd_code_s == CMD_CLEAR);

    // Unsigned 32-bit subtraction wraps, so samples stay correct when the
    // counter rolls over between START and the capture.
    assign elapsed_s  = counter_in - base_r;

    // LAP and STOP only record a sample while counting.
    assign capture_s    = (do_lap_s || do_stop_s) && (state_r == ST_COUNTING);
    assign fifo_empty_s = (count_r == CNT_ZERO);
    assign fifo_full_s  = (count_r == DEPTH_CNT);
    assign pop_s        = read && (address == ADDR_DATA) && !fifo_empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_s       = capture_s && (!fifo_full_s || pop_s);
    assign drop_s       = capture_s && fifo_full_s && !pop_s;

    // Next-state logic of the measurement FSM.
    always_comb begin
        state_nxt_s = state_r;
        if (do_start_s) begin
            state_nxt_s = ST_COUNTING;
        end else if (do_stop_s && (state_r == ST_COUNTING)) begin
            state_nxt_s = ST_STOPPED;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Trigger code decoded from the next state so the counter sees the new
    // value right after the command edge.
    always_comb begin
        trigger_nxt_s = TRIG_IDLE;
        case (state_nxt_s)
            ST_IDLE:     trigger_nxt_s = TRIG_IDLE;
            ST_COUNTING: trigger_nxt_s = TRIG_COUNT;
            ST_STOPPED:  trigger_nxt_s = TRIG_STOPPED;
            default:     trigger_nxt_s = TRIG_IDLE;
        endcase
    end

    // FSM state, trigger output and START base capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            trigger_r <= TRIG_IDLE;
            base_r    <= 32'd0;
        end else begin
            state_r   <= state_nxt_s;
            trigger_r <= trigger_nxt_s;
            if (do_start_s) begin
                base_r <= counter_in;
            end
        end
    end

    // Sample FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else if (do_clear_s) begin
            // A DATA read in this cycle still returns the old head via
            // rd_mux_s; the FIFO simply ends up empty.
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= elapsed_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Last captured sample, updated even when the push is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= 32'd0;
        end else if (capture_s) begin
            last_r <= elapsed_s;
        end
    end

`ifdef CYCLE_MEASURE_MAXLAP_EN
    // Largest captured sample, including captures dropped on a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_r <= 32'd0;
        end else if (do_clear_s) begin
            max_r <= 32'd0;
        end else if (capture_s && (elapsed_s > max_r)) begin
            max_r <= elapsed_s;
        end
    end
`endif

    // STATUS word assembled from live state.
    always_comb begin
        status_s            = 32'd0;
        status_s[1:0]       = state_r;
        status_s[2]         = overflow_r;
        status_s[3]         = fifo_full_s;
        status_s[4]         = fifo_empty_s;
        status_s[8 +: CNT_W] = count_r;
        status_s[31]        = MAXLAP_FLAG;
    end

    // Read data multiplexer; CMD and unmapped addresses return zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            ADDR_STATUS: rd_mux_s = status_s;
            ADDR_DATA:   rd_mux_s = fifo_empty_s ? 32'd0 : mem_r[rd_ptr_r];
            ADDR_LAST:   rd_mux_s = last_r;
`ifdef CYCLE_MEASURE_MAXLAP_EN
            ADDR_MAX:    rd_mux_s = max_r;
`endif
            default:     rd_mux_s = 32'd0;
        endcase
    end

    // Registered read port: data held between reads, valid is a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r       <= 32'd0;
            readdata_valid_r <= 1'b0;
        end else if (read) begin
            readdata_r       <= rd_mux_s;
            readdata_valid_r <= 1'b1;
        end else begin
            readdata_valid_r <= 1'b0;
        end
    end

    assign readdata       = readdata_r;
    assign readdata_valid = readdata_valid_r;
    assign trigger        = trigger_r;

endmodule

// File: tb/tb_cycle_measure_ctrl.sv
// Testbench for cycle_measure_ctrl: directed scenarios plus a randomized
// command/read stream checked against a queue-based reference model. The
// external cycle counter is modelled here and increments while trigger==1.
module tb_cycle_measure_ctrl;

    localparam int DEPTH = 8;
`ifdef CYCLE_MEASURE_MAXLAP_EN
    localparam logic [31:0] MAXBIT = 32'h8000_0000;
    localparam bit          MAXON  = 1'b1;
`else
    localparam logic [31:0] MAXBIT = 32'h0000_0000;
    localparam bit          MAXON  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic        read;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdata_valid;
    logic [31:0] trigger;
    logic [31:0] counter_in;

    logic [31:0] cnt;
    logic        preset_en;
    logic [31:0] preset_val;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_state;
    logic [31:0] m_base;
    logic [31:0] m_last;
    logic [31:0] m_max;
    logic        m_ovf;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    assign counter_in = cnt;

    // external cycle counter
    always @(posedge clk) begin
        if (preset_en) cnt <= preset_val;
        else if (trigger == 32'd1) cnt <= cnt + 32'd1;
    end

    cycle_measure_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .readdata_valid(readdata_valid), .trigger(trigger),
        .counter_in(counter_in)
    );

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] s;
        s = MAXBIT;
        s[1:0] = 2'(m_state);
        s[2]   = m_ovf;
        s[3]   = (q.size() == DEPTH);
        s[4]   = (q.size() == 0);
        s[11:8] = 4'(q.size());
        case (a)
            8'h04:   model_read = s;
            8'h08:   model_read = (q.size() > 0) ? q[0] : 32'd0;
            8'h0C:   model_read = m_last;
            8'h10:   model_read = MAXON ? m_max : 32'd0;
            default: model_read = 32'd0;
        endcase
    endfunction

    task automatic capture(input logic [31:0] v);
        m_last = v;
        if (v > m_max) m_max = v;
        if (q.size() < DEPTH) q.push_back(v);
        else m_ovf = 1'b1;
    endtask

    task automatic model_reset();
        m_state = 0; m_base = 32'd0; m_last = 32'd0; m_max = 32'd0;
        m_ovf = 1'b0; q.delete();
    endtask

    // One clock: drive at negedge, update model, return at next negedge.
    task automatic step(input logic w, input logic r, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rexp);
        logic [31:0] c;
        write = w; read = r; address = a; writedata = d;
        c = cnt;
        rexp = model_read(a);
        if (r && a == 8'h08 && q.size() > 0) void'(q.pop_front());
        if (w && a == 8'h00) begin
            case (d[2:0])
                3'd1: begin m_state = 1; m_base = c; end
                3'd2: if (m_state == 1) begin capture(c - m_base); m_state = 2; end
                3'd3: if (m_state == 1) capture(c - m_base);
                3'd4: begin q.delete(); m_ovf = 1'b0; m_max = 32'd0; end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        write = 1'b0; read = 1'b0; address = 8'h00; writedata = 32'd0;
    endtask

    task automatic idle(input int n);
        logic [31:0] dummy;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 32'd0, dummy);
    endtask

    task automatic do_reset();
        write = 1'b0; read = 1'b0; address = 8'h00; writedata = 32'd0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset();
        n_vec++; if (trigger !== 32'd0) begin n_err++; $display("FAIL reset_trigger got=%h exp=%h", trigger, 32'd0); end
        n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'd0); end
        n_vec++; if (readdata_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", readdata_valid); end
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h10 | MAXBIT)) begin n_err++; $display("FAIL reset_status got=%h exp=%h", readdata, 32'h10 | MAXBIT); end
        n_vec++; if (readdata_valid !== 1'b1) begin n_err++; $display("FAIL reset_rvalid got=%b exp=1", readdata_valid); end
    endtask

    task automatic test_start_stop();
        logic [31:0] e;
        int ones;
        ones = 0;
        step(1'b1, 1'b0, 8'h00, 32'd1, e);
        if (trigger === 32'd1) ones++;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 8'h00, 32'd0, e);
            if (trigger === 32'd1) ones++;
        end
        step(1'b1, 1'b0, 8'h00, 32'd2, e);
        n_vec++; if (ones != 10) begin n_err++; $display("FAIL ss_trigger_ones got=%0d exp=10", ones); end
        n_vec++; if (trigger !== 32'd2) begin n_err++; $display("FAIL ss_trigger_stop got=%h exp=2", trigger); end
        step(1'b0, 1'b1, 8'h08, 32'd0, e);
        n_vec++; if (readdata !== 32'd9) begin n_err++; $display("FAIL ss_data got=%0d exp=9", readdata); end
        step(1'b0, 1'b1, 8'h0C, 32'd0, e);
        n_vec++; if (readdata !== 32'd9) begin n_err++; $display("FAIL ss_last got=%0d exp=9", readdata); end
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h12 | MAXBIT)) begin n_err++; $display("FAIL ss_status got=%h exp=%h", readdata, 32'h12 | MAXBIT); end
    endtask

    task automatic test_laps();
        logic [31:0] e;
        logic [31:0] exp_v [4];
        exp_v[0] = 32'd4; exp_v[1] = 32'd11; exp_v[2] = 32'd19; exp_v[3] = 32'd0;
        step(1'b1, 1'b0, 8'h00, 32'd1, e);   // edge t
        idle(4);
        step(1'b1, 1'b0, 8'h00, 32'd3, e);   // t+5
        idle(6);
        step(1'b1, 1'b0, 8'h00, 32'd3, e);   // t+12
        idle(7);
        step(1'b1, 1'b0, 8'h00, 32'd2, e);   // t+20
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h08, 32'd0, e);
            n_vec++; if (readdata !== exp_v[i]) begin n_err++; $display("FAIL laps_data%0d got=%0d exp=%0d", i, readdata, exp_v[i]); end
        end
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h12 | MAXBIT)) begin n_err++; $display("FAIL laps_status got=%h exp=%h", readdata, 32'h12 | MAXBIT); end
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        preset_val = 32'hFFFF_FFFA;
        preset_en  = 1'b1;
        idle(1);
        preset_en  = 1'b0;
        step(1'b1, 1'b0, 8'h00, 32'd1, e);
        idle(9);
        step(1'b1, 1'b0, 8'h00, 32'd2, e);
        step(1'b0, 1'b1, 8'h08, 32'd0, e);
        n_vec++; if (readdata !== 32'd9) begin n_err++; $display("FAIL wrap_data got=%h exp=9", readdata); end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        step(1'b1, 1'b0, 8'h00, 32'd4, e);
        step(1'b1, 1'b0, 8'h00, 32'd1, e);   // edge t
        for (int j = 1; j <= 9; j++) begin
            if (j == 9) begin
                step(1'b0, 1'b1, 8'h04, 32'd0, e);
                n_vec++; if (readdata !== (32'h809 | MAXBIT)) begin n_err++; $display("FAIL ovf_full_status got=%h exp=%h", readdata, 32'h809 | MAXBIT); end
            end else begin
                idle(1);
            end
            step(1'b1, 1'b0, 8'h00, 32'd3, e);   // t+2j -> 2j-1
        end
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h80D | MAXBIT)) begin n_err++; $display("FAIL ovf_status got=%h exp=%h", readdata, 32'h80D | MAXBIT); end
        step(1'b0, 1'b1, 8'h0C, 32'd0, e);
        n_vec++; if (readdata !== 32'd17) begin n_err++; $display("FAIL ovf_last got=%0d exp=17", readdata); end
        step(1'b0, 1'b1, 8'h08, 32'd0, e);
        n_vec++; if (readdata !== 32'd1) begin n_err++; $display("FAIL ovf_head got=%0d exp=1", readdata); end
        step(1'b1, 1'b0, 8'h00, 32'd3, e);
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h80D | MAXBIT)) begin n_err++; $display("FAIL ovf_sticky got=%h exp=%h", readdata, 32'h80D | MAXBIT); end
        step(1'b1, 1'b0, 8'h00, 32'd4, e);
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h11 | MAXBIT)) begin n_err++; $display("FAIL ovf_clear got=%h exp=%h", readdata, 32'h11 | MAXBIT); end
    endtask

    task automatic test_maxlap();
        logic [31:0] e;
        logic [31:0] exp_max;
        exp_max = MAXON ? 32'd11 : 32'd0;
        step(1'b1, 1'b0, 8'h00, 32'd1, e);
        idle(4);
        step(1'b1, 1'b0, 8'h00, 32'd3, e);   // 4
        idle(6);
        step(1'b1, 1'b0, 8'h00, 32'd3, e);   // 11
        step(1'b1, 1'b0, 8'h00, 32'd1, e);
        idle(7);
        step(1'b1, 1'b0, 8'h00, 32'd3, e);   // 7
        step(1'b0, 1'b1, 8'h10, 32'd0, e);
        n_vec++; if (readdata !== exp_max) begin n_err++; $display("FAIL maxlap got=%0d exp=%0d", readdata, exp_max); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        step(1'b1, 1'b0, 8'h00, 32'd1, e);
        idle(3);
        step(1'b1, 1'b0, 8'h00, 32'd3, e);
        do_reset();
        n_vec++; if (trigger !== 32'd0) begin n_err++; $display("FAIL mid_trigger got=%h exp=0", trigger); end
        step(1'b0, 1'b1, 8'h04, 32'd0, e);
        n_vec++; if (readdata !== (32'h10 | MAXBIT)) begin n_err++; $display("FAIL mid_status got=%h exp=%h", readdata, 32'h10 | MAXBIT); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic [7:0]  atab [10];
        logic [7:0]  a;
        logic        w;
        logic        r;
        atab[0] = 8'h00; atab[1] = 8'h00; atab[2] = 8'h00; atab[3] = 8'h04;
        atab[4] = 8'h08; atab[5] = 8'h08; atab[6] = 8'h0C; atab[7] = 8'h10;
        atab[8] = 8'h14; atab[9] = 8'hFF;
        for (int i = 0; i < 400; i++) begin
            a = atab[$urandom_range(0, 9)];
            w = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 1) == 1);
            step(w, r, a, {$urandom_range(0, 1) == 1 ? 29'h1FFF_FFFF : 29'd0, 3'($urandom_range(0, 7))}, e);
            n_vec++; if (trigger !== 32'(m_state)) begin n_err++; $display("FAIL rnd_trigger cyc=%0d got=%h exp=%h", i, trigger, 32'(m_state)); end
            n_vec++; if (readdata_valid !== r) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, readdata_valid, r); end
            if (r) begin
                n_vec++; if (readdata !== e) begin n_err++; $display("FAIL rnd_read cyc=%0d addr=%h got=%h exp=%h", i, a, readdata, e); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; address = 8'h00; writedata = 32'd0;
        preset_en = 1'b1; preset_val = 32'h0000_0100;
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        preset_en = 1'b0;
        test_reset();
        test_start_stop();
        test_laps();
        test_wrap();
        test_overflow();
        test_maxlap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
